// File: rtl/softmax_pkg.sv
// Shared constants and helpers for the softmax front end.
// Row geometry, pad value, length codes and mode decode.
package softmax_pkg;

    localparam int DATA_W  = 16;
    localparam int MAX_LEN = 64;
    localparam int CNT_W   = 7;
    localparam int FLAT_W  = DATA_W * MAX_LEN;

    localparam logic [DATA_W-1:0] PAD_VAL = 16'h8000;

    localparam logic [1:0] LEN16 = 2'd0;
    localparam logic [1:0] LEN32 = 2'd1;
    localparam logic [1:0] LEN64 = 2'd2;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        HOLD
    } pk_state_t;

    // Unknown code 3 falls back to a full row.
    function automatic logic [CNT_W-1:0] mode_len(input logic [1:0] mode);
        logic [CNT_W-1:0] n;
        case (mode)
            LEN16:   n = 7'd16;
            LEN32:   n = 7'd32;
            default: n = 7'd64;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/softmax_row_packer_lane_pad_mask.sv
// Lane-valid mask: lanes below cnt carry real data.
// Purely combinational, drives the pad mux in the packer.
module lane_pad_mask
    import softmax_pkg::*;
(
    input  logic [CNT_W-1:0]   cnt,
    output logic [MAX_LEN-1:0] mask
);

    // Thermometer decode of the filled-lane count.
    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(cnt));
        end
    end

endmodule

// File: rtl/softmax_row_packer.sv
// Packs a stream of Q8.8 scores into one padded 64-lane row
// and strobes it to softmax_approx for one enabled cycle.
module softmax_row_packer
    import softmax_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic [1:0]        s_mode,
    input  logic              s_last,
    output logic              valid_in,
    output logic [FLAT_W-1:0] in_x_flat,
    output logic [1:0]        length_mode,
    output logic              mode_err,
    output logic [15:0]       row_cnt
);

    pk_state_t          state;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   n_q;
    logic [1:0]         mode_q;
    logic               rdy_q;
    logic [DATA_W-1:0]  lane_buf [MAX_LEN];
    logic [MAX_LEN-1:0] lane_mask;
    logic [FLAT_W-1:0]  padded;
    logic               acc;
    logic               close;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [CNT_W-1:0]   n_cur;
    logic [5:0]         wr_idx;

    // rdy_q is a registered copy of "not HOLD", held low out of reset.
    assign s_ready = en & rdy_q;
    assign acc     = s_valid & s_ready;
    assign n_cur   = (state == IDLE) ? mode_len(s_mode) : n_q;
    assign cnt_nxt = (state == IDLE) ? 7'd1 : cnt + 7'd1;
    assign wr_idx  = (state == IDLE) ? 6'd0 : cnt[5:0];
    assign close   = s_last | (cnt_nxt == n_cur);

    lane_pad_mask u_mask (
        .cnt  (cnt),
        .mask (lane_mask)
    );

    // Replace unfilled lanes with the pad value.
    always_comb begin
        padded = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            padded[i*DATA_W +: DATA_W] = lane_mask[i] ? lane_buf[i] : PAD_VAL;
        end
    end

    // Assembly buffer: one lane written per accepted element.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                lane_buf[i] <= '0;
            end
        end else if (acc) begin
            lane_buf[wr_idx] <= s_data;
        end
    end

    // Row FSM with registered strobe, row output and counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            n_q         <= '0;
            mode_q      <= '0;
            rdy_q       <= 1'b0;
            valid_in    <= 1'b0;
            in_x_flat   <= '0;
            length_mode <= '0;
            mode_err    <= 1'b0;
            row_cnt     <= '0;
        end else if (en) begin
            valid_in <= 1'b0;
            unique case (state)
                IDLE, FILL: begin
                    rdy_q <= 1'b1;
                    if (acc) begin
                        cnt <= cnt_nxt;
                        if (state == IDLE) begin
                            n_q    <= n_cur;
                            mode_q <= (s_mode == 2'd3) ? LEN64 : s_mode;
                            if (s_mode == 2'd3) begin
                                mode_err <= 1'b1;
                            end
                        end
                        if (close) begin
                            state <= HOLD;
                            rdy_q <= 1'b0;
                        end else begin
                            state <= FILL;
                        end
                    end
                end
                HOLD: begin
                    in_x_flat   <= padded;
                    length_mode <= mode_q;
                    valid_in    <= 1'b1;
                    row_cnt     <= row_cnt + 16'd1;
                    rdy_q       <= 1'b1;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_softmax_row_packer.sv
// Scoreboard bench for softmax_row_packer.
// Driver queues expected rows; a negedge monitor checks strobes.
module tb_softmax_row_packer;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          s_valid;
    logic          s_ready;
    logic [15:0]   s_data;
    logic [1:0]    s_mode;
    logic          s_last;
    logic          valid_in;
    logic [1023:0] in_x_flat;
    logic [1:0]    length_mode;
    logic          mode_err;
    logic [15:0]   row_cnt;

    typedef struct {
        logic [1023:0] flat;
        logic [1:0]    mode;
        logic [15:0]   rows;
        logic          merr;
        int            lat;
    } exp_t;

    exp_t        exp_q[$];
    int          len_q[$];
    int          t0_q[$];
    logic [15:0] dvec [64];
    int          n_vec = 0;
    int          n_err = 0;
    int          rows_m = 0;
    bit          merr_m = 0;

    softmax_row_packer dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_mode      (s_mode),
        .s_last      (s_last),
        .valid_in    (valid_in),
        .in_x_flat   (in_x_flat),
        .length_mode (length_mode),
        .mode_err    (mode_err),
        .row_cnt     (row_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [1023:0] a,
                       input logic [1023:0] e);
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, a, e);
        end
    endtask

    task automatic wait_accept();
        bit ok = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (s_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 1024'(0), 1024'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic send_row(input logic [1:0] mode, input int len,
                            input bit use_dvec, input int stall_at,
                            input bit hold_stall, input int abort_at);
        int          n;
        logic [15:0] d [64];
        exp_t        e;
        n = (mode == 2'd0) ? 16 : (mode == 2'd1) ? 32 : 64;
        for (int i = 0; i < 64; i++) begin
            d[i] = use_dvec ? dvec[i] : 16'($urandom);
        end
        if (abort_at < 0) begin
            if (mode == 2'd3) merr_m = 1;
            rows_m++;
            for (int i = 0; i < 64; i++) begin
                e.flat[i*16 +: 16] = (i < len) ? d[i] : 16'h8000;
            end
            e.mode = (mode == 2'd3) ? 2'd2 : mode;
            e.rows = 16'(rows_m);
            e.merr = merr_m;
            e.lat  = len + 1 + ((stall_at >= 0) ? 3 : 0) + (hold_stall ? 3 : 0);
            exp_q.push_back(e);
        end
        len_q.push_back(len);
        for (int i = 0; i < len; i++) begin
            if (i == abort_at) begin
                rst = 0;
                #1;
                chk("rst_valid_in", 1024'(valid_in), 1024'(0));
                chk("rst_flat", in_x_flat, 1024'(0));
                chk("rst_length_mode", 1024'(length_mode), 1024'(0));
                chk("rst_mode_err", 1024'(mode_err), 1024'(0));
                chk("rst_row_cnt", 1024'(row_cnt), 1024'(0));
                chk("rst_s_ready", 1024'(s_ready), 1024'(0));
                s_valid = 0;
                s_last  = 0;
                len_q.delete();
                t0_q.delete();
                merr_m = 0;
                rows_m = 0;
                @(posedge clk);
                #1;
                rst = 1;
                return;
            end
            if (i == stall_at) begin
                en      = 0;
                s_valid = 1;
                s_data  = 16'($urandom);
                repeat (3) @(posedge clk);
                #1;
                en = 1;
            end
            s_valid = 1;
            s_data  = d[i];
            s_mode  = (i == 0) ? mode : 2'($urandom);
            s_last  = (i == len - 1) && (len < n || ($urandom % 2) == 1);
            wait_accept();
        end
        s_valid = 0;
        s_last  = 0;
        if (hold_stall) begin
            en = 0;
            repeat (3) @(posedge clk);
            #1;
            en = 1;
        end
    endtask

    // Monitor: pops the scoreboard on each new strobe, checks freezes.
    int            cyc = 0;
    int            rem = 0;
    logic          prev_valid = 0;
    logic          prev_en = 1;
    logic [1023:0] prev_flat = '0;
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!rst) begin
            rem = 0;
        end else begin
            if (valid_in && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", 1024'(1), 1024'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("row_flat", in_x_flat, e.flat);
                    chk("length_mode", 1024'(length_mode), 1024'(e.mode));
                    chk("row_cnt", 1024'(row_cnt), 1024'(e.rows));
                    chk("mode_err", 1024'(mode_err), 1024'(e.merr));
                    if (t0_q.size() != 0) begin
                        chk("latency", 1024'(cyc - t0_q.pop_front()), 1024'(e.lat));
                    end else begin
                        chk("latency_no_start", 1024'(1), 1024'(0));
                    end
                end
            end
            if (!en) begin
                chk("ready_while_stalled", 1024'(s_ready), 1024'(0));
                if (!prev_en) begin
                    chk("frozen_valid_in", 1024'(valid_in), 1024'(prev_valid));
                    chk("frozen_flat", in_x_flat, prev_flat);
                end
            end
            if (s_valid && s_ready) begin
                if (rem == 0 && len_q.size() != 0) begin
                    rem = len_q.pop_front();
                    t0_q.push_back(cyc);
                end
                if (rem > 0) rem--;
            end
        end
        prev_valid = valid_in;
        prev_flat  = in_x_flat;
        prev_en    = en;
    end

    initial begin
        int n;
        int len;
        logic [1:0] m;
        rst     = 0;
        en      = 1;
        s_valid = 0;
        s_data  = '0;
        s_mode  = '0;
        s_last  = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_valid_in", 1024'(valid_in), 1024'(0));
        chk("reset_flat", in_x_flat, 1024'(0));
        chk("reset_row_cnt", 1024'(row_cnt), 1024'(0));
        chk("reset_s_ready", 1024'(s_ready), 1024'(0));
        @(posedge clk);
        #1;
        rst = 1;

        for (int i = 0; i < 64; i++) dvec[i] = 16'((i + 1) * 256);
        send_row(2'd0, 16, 1, -1, 0, -1);
        send_row(2'd2, 64, 0, -1, 0, -1);
        send_row(2'd1, 32, 0, -1, 0, -1);

        dvec[0] = 16'h061D;
        dvec[1] = 16'hFDE2;
        dvec[2] = 16'h0B13;
        dvec[3] = 16'hFBCF;
        dvec[4] = 16'h0B26;
        send_row(2'd1, 5, 1, -1, 0, -1);

        send_row(2'd0, 16, 0, 6, 1, -1);
        send_row(2'd3, 64, 0, -1, 0, -1);
        send_row(2'd1, 20, 0, -1, 0, -1);

        repeat (30) @(posedge clk);
        #1;
        send_row(2'd0, 16, 0, -1, 0, 10);
        send_row(2'd0, 16, 0, -1, 0, -1);

        for (int r = 0; r < 20; r++) begin
            m   = 2'($urandom % 4);
            n   = (m == 2'd0) ? 16 : (m == 2'd1) ? 32 : 64;
            len = ($urandom % 2 == 0) ? n : int'($urandom_range(1, n));
            send_row(m, len, 0, (r % 7 == 3) ? 2 : -1, (r % 5 == 1), -1);
        end

        for (int k = 0; k < 500 && exp_q.size() != 0; k++) @(posedge clk);
        while (exp_q.size() != 0) begin
            void'(exp_q.pop_front());
            chk("missing_strobe", 1024'(0), 1024'(1));
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
